// File: rtl/commit_regfile_pkg.sv
// commit_regfile_pkg: shared Tomasulo sizing and dump FSM encoding
package commit_regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int IDX_W = $clog2(NREG);
  typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_DONE} dump_state_e;
endpackage

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: serial dump sequencer producing index, valid and done
module regfile_dump_ctrl #(
  parameter int NREG = commit_regfile_pkg::NREG
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                dump_start,
  output logic                                dump_valid,
  output logic [commit_regfile_pkg::IDX_W-1:0] dump_idx,
  output logic                                dump_done
);
  import commit_regfile_pkg::*;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NREG - 1);
  dump_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (dump_start) begin
        state_d = ST_DUMP;
        idx_d   = '0;
        valid_d = 1'b1;
      end
      ST_DUMP: if (idx_q == LAST) begin
        state_d = ST_DONE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  assign dump_valid = valid_q;
  assign dump_idx   = idx_q;
  assign dump_done  = done_q;
endmodule

// File: rtl/commit_regfile.sv
// commit_regfile: architectural register file written at commit, with bypassed
// registered read ports and a serial dump port
module commit_regfile #(
  parameter int XLEN = commit_regfile_pkg::XLEN,
  parameter int NREG = commit_regfile_pkg::NREG
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                commit_wen,
  input  logic [commit_regfile_pkg::IDX_W-1:0] commit_idx,
  input  logic [XLEN-1:0]                     commit_data,
  input  logic [commit_regfile_pkg::IDX_W-1:0] rs1,
  input  logic [commit_regfile_pkg::IDX_W-1:0] rs2,
  output logic [XLEN-1:0]                     Vj,
  output logic [XLEN-1:0]                     Vk,
  input  logic                                dump_start,
  output logic                                dump_valid,
  output logic [commit_regfile_pkg::IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]                     dump_data,
  output logic                                dump_done,
  output logic [15:0]                         commit_count
);
  import commit_regfile_pkg::*;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [15:0]     commit_count_q, commit_count_d;
  logic            wr;
  assign wr = commit_wen && commit_idx != '0;
  always_comb begin
    regs_d = regs_q;
    if (wr) regs_d[commit_idx] = commit_data;
    // r0 is never written, so its storage stays zero for both reads and bypass
    vj_d = (wr && commit_idx == rs1) ? commit_data : regs_q[rs1];
    vk_d = (wr && commit_idx == rs2) ? commit_data : regs_q[rs2];
    commit_count_d = commit_count_q + 16'(commit_wen);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q         <= '{default: '0};
      vj_q           <= '0;
      vk_q           <= '0;
      commit_count_q <= '0;
    end else begin
      regs_q         <= regs_d;
      vj_q           <= vj_d;
      vk_q           <= vk_d;
      commit_count_q <= commit_count_d;
    end
  end
  regfile_dump_ctrl #(.NREG(NREG)) u_dump (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_done  (dump_done)
  );
  assign dump_data    = dump_valid ? regs_q[dump_idx] : '0;
  assign Vj           = vj_q;
  assign Vk           = vk_q;
  assign commit_count = commit_count_q;
endmodule

// File: tb/tb_commit_regfile.sv
// tb_commit_regfile: directed self-checking bench for commit_regfile
module tb_commit_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_wen = 1'b0;
  logic [4:0]  commit_idx = '0;
  logic [31:0] commit_data = '0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic [31:0] Vj, Vk, dump_data;
  logic        dump_start = 1'b0, dump_valid, dump_done;
  logic [4:0]  dump_idx;
  logic [15:0] commit_count;
  int          checks = 0, errors = 0;
  logic        seen_done;

  commit_regfile dut (
    .clk(clk), .rst(rst), .commit_wen(commit_wen), .commit_idx(commit_idx),
    .commit_data(commit_data), .rs1(rs1), .rs2(rs2), .Vj(Vj), .Vk(Vk),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_done(dump_done), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic commit(input logic [4:0] idx, input logic [31:0] data);
    commit_wen = 1'b1; commit_idx = idx; commit_data = data;
    tick;
    commit_wen = 1'b0;
  endtask

  initial begin
    tick; tick;
    chk("rst_vj", Vj, 0);
    chk("rst_vk", Vk, 0);
    chk("rst_count", 32'(commit_count), 0);
    chk("rst_valid", 32'(dump_valid), 0);
    chk("rst_done", 32'(dump_done), 0);
    chk("rst_didx", 32'(dump_idx), 0);
    chk("rst_ddata", dump_data, 0);
    rst = 1'b0;
    tick;

    commit(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5; tick;
    chk("r5_read", Vj, 32'hDEADBEEF);
    chk("count_1", 32'(commit_count), 1);

    commit(5'd0, 32'h1234);
    rs1 = 5'd0; tick;
    chk("r0_read", Vj, 0);
    chk("count_2", 32'(commit_count), 2);
    commit(5'd0, 32'h1234);
    chk("r0_bypass", Vj, 0);
    chk("count_3", 32'(commit_count), 3);

    rs1 = 5'd7; rs2 = 5'd7;
    commit(5'd7, 32'hA5A5A5A5);
    chk("byp_vj", Vj, 32'hA5A5A5A5);
    chk("byp_vk", Vk, 32'hA5A5A5A5);
    rs1 = 5'd5; rs2 = 5'd9;
    commit(5'd9, 32'h99);
    chk("mix_vj", Vj, 32'hDEADBEEF);
    chk("mix_vk", Vk, 32'h99);
    chk("count_5", 32'(commit_count), 5);

    for (int i = 1; i < 32; i++) commit(5'(i), 32'(i * 3));
    rs1 = 5'd31; rs2 = 5'd7; tick;
    chk("pre_r31", Vj, 93);
    chk("pre_r7", Vk, 21);

    dump_start = 1'b1; tick; dump_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("dump_valid", 32'(dump_valid), 1);
      chk("dump_idx", 32'(dump_idx), 32'(i));
      chk("dump_data", dump_data, (i == 20) ? 32'h2020 : 32'(i * 3));
      chk("dump_nodone", 32'(dump_done), 0);
      dump_start = (i >= 3 && i <= 5);
      commit_wen = (i == 10 || i == 11);
      commit_idx = (i == 10) ? 5'd20 : 5'd2;
      commit_data = (i == 10) ? 32'h2020 : 32'hBAD;
      tick;
    end
    commit_wen = 1'b0; dump_start = 1'b0;
    chk("done_pulse", 32'(dump_done), 1);
    chk("done_valid", 32'(dump_valid), 0);
    dump_start = 1'b1; tick; dump_start = 1'b0;
    chk("done_once", 32'(dump_done), 0);
    chk("idle_valid", 32'(dump_valid), 0);
    tick;
    chk("no_restart", 32'(dump_valid), 0);
    chk("count_38", 32'(commit_count), 38);
    rs1 = 5'd2; tick;
    chk("r2_dumpcommit", Vj, 32'hBAD);

    dump_start = 1'b1; tick; dump_start = 1'b0;
    for (int k = 0; k < 40 && dump_idx != 5'd10; k++) tick;
    chk("reach_idx10", 32'(dump_idx), 10);
    rst = 1'b1; #1;
    chk("abort_valid", 32'(dump_valid), 0);
    chk("abort_idx", 32'(dump_idx), 0);
    chk("abort_data", dump_data, 0);
    chk("abort_count", 32'(commit_count), 0);
    chk("abort_vj", Vj, 0);
    seen_done = dump_done;
    repeat (3) begin tick; seen_done |= dump_done; end
    rst = 1'b0;
    repeat (40) begin tick; seen_done |= dump_done; end
    chk("abort_nodone", 32'(seen_done), 0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i); tick;
      chk("post_rst_vj", Vj, 0);
      chk("post_rst_vk", Vk, 0);
    end

    commit_wen = 1'b1; commit_idx = 5'd0; commit_data = 32'hFFFF;
    repeat (65536) tick;
    chk("count_wrap0", 32'(commit_count), 0);
    tick;
    commit_wen = 1'b0;
    chk("count_wrap1", 32'(commit_count), 1);
    rs1 = 5'd0; tick;
    chk("r0_after_wrap", Vj, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_regfile.md
COMMIT_REGFILE -- requirements
Module: commit_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width of each architectural register.
REQ-002 The block SHALL have parameter NREG, default 32, meaning number of architectural registers; index width is log2(NREG) = 5.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port commit_wen  input  1  commit write strobe from the order manager.
REQ-006 The block SHALL have port commit_idx  input  5  destination register of the commit.
REQ-007 The block SHALL have port commit_data  input  XLEN  value being committed.
REQ-008 The block SHALL have port rs1  input  5  source-1 index from the decoder.
REQ-009 The block SHALL have port rs2  input  5  source-2 index from the decoder.
REQ-010 The block SHALL have port Vj  output  XLEN  registered value of rs1, sent to the reservation stations.
REQ-011 The block SHALL have port Vk  output  XLEN  registered value of rs2, sent to the reservation stations.
REQ-012 The block SHALL have port dump_start  input  1  pulse that requests a serial dump of all registers.
REQ-013 The block SHALL have port dump_valid  output  1  high while dump_idx/dump_data carry a dumped register.
REQ-014 The block SHALL have port dump_idx  output  5  index of the register being dumped.
REQ-015 The block SHALL have port dump_data  output  XLEN  value of the register being dumped.
REQ-016 The block SHALL have port dump_done  output  1  one-cycle pulse after the last dumped register.
REQ-017 The block SHALL have port commit_count  output  16  number of accepted commits, wrapping modulo 2^16.

Function
REQ-018 On a rising edge with commit_wen=1 and commit_idx!=0, the block SHALL write commit_data to register commit_idx.
REQ-019 Register 0 SHALL always read 0; commits to index 0 SHALL be discarded, although commit_count SHALL still increment.
REQ-020 commit_count SHALL increment by 1 on every edge with commit_wen=1, wrapping from 0xFFFF to 0x0000.
REQ-021 Vj and Vk SHALL be registered with 1-cycle latency: the values presented at edge N SHALL reflect rs1/rs2 sampled at edge N.
REQ-022 Write-through bypass: if commit_wen=1, commit_idx==rs1 and rs1!=0 on the same edge, Vj SHALL take commit_data; the same rule SHALL apply to rs2/Vk.
REQ-023 rs1==rs2 SHALL produce identical Vj and Vk, including under bypass.
REQ-024 The dump FSM SHALL have states IDLE, DUMP and DONE.
REQ-025 Dump transition IDLE->DUMP SHALL occur when dump_start=1; the dump index SHALL be cleared to 0.
REQ-026 In DUMP, each cycle the block SHALL assert dump_valid with dump_idx=i and dump_data equal to register i as of that cycle; i SHALL step by one per cycle.
REQ-027 Dump transition DUMP->DONE SHALL occur after i=NREG-1 is presented.
REQ-028 In DONE, dump_done SHALL be high for exactly one cycle, dump_valid SHALL be 0, and the FSM SHALL return to IDLE.
REQ-029 dump_start SHALL be ignored in DUMP and DONE.
REQ-030 A commit during a dump SHALL update storage normally; a register not yet dumped SHALL appear with the new value, and an already-dumped register SHALL not be re-emitted.
REQ-031 Commits and reads SHALL never stall and SHALL have no handshake; the block SHALL accept one commit per cycle.

Reset
REQ-032 While rst=1, all registers SHALL be 0, and Vj, Vk, commit_count, dump_idx and dump_data SHALL be 0.
REQ-033 While rst=1, dump_valid and dump_done SHALL be 0 and the FSM SHALL be in IDLE.
REQ-034 Assertion of rst mid-dump SHALL abort the dump immediately with no dump_done pulse.
REQ-035 The first edge after rst deasserts SHALL be a normal operating cycle.

Structure
REQ-036 XLEN, NREG, the register-index width and the dump FSM state encoding SHALL live in the shared Tomasulo package used by the order manager and the reservation stations.
REQ-037 The dump FSM SHALL be one sub-module, regfile_dump_ctrl, which outputs the dump index and valid/done signals; storage and the read ports SHALL stay in commit_regfile.

Verification
REQ-038 The bench SHALL cover: reset, then commit idx=5 data=0xDEADBEEF, then rs1=5 -> Vj=0xDEADBEEF one cycle later, and commit_count=1.
REQ-039 The bench SHALL cover: commit idx=0 data=0x1234, then rs1=0 -> Vj=0 and commit_count incremented.
REQ-040 The bench SHALL cover: same edge commit idx=7 data=0xA5A5A5A5 with rs1=7, rs2=7 -> Vj=Vk=0xA5A5A5A5 at the next cycle.
REQ-041 The bench SHALL cover: preload r1..r31 = index*3, pulse dump_start -> 32 consecutive dump_valid cycles with idx 0..31 and data 0,3,...,93, then a single dump_done.
REQ-042 The bench SHALL cover: 65537 commits -> commit_count=1.
REQ-043 The bench SHALL cover: rst asserted at dump_idx=10 -> dump_valid=0 immediately, no dump_done, all registers read 0 afterward.
